beep_melody_ctrl: RTL and testbench

BEEP_MELODY_CTRL -- requirements
Module: beep_melody_ctrl

---
 rtl/beep_melody_ctrl.sv | 145 ++++++++++++++
 tb/tb_beep_melody_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/beep_melody_ctrl.sv
// +----------------------------------------------------------------------------+
// | beep_melody_ctrl: plays a fixed note table or passes UART digit keys       |
// | through to the beep generator KEY input.                                    |
// | Optional: define UART_PREEMPT_EN to let a UART digit abort playback.        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module beep_melody_ctrl #(
  parameter int NOTE_TICKS = 12500000,
  parameter int GAP_TICKS  = 2500000,
  parameter int SONG_LEN   = 8
) (
  input  logic       CLK_50M,
  input  logic       RST_N,
  input  logic [7:0] UART_DATA,
  input  logic       UART_VALID,
  input  logic       PLAY_START,
  input  logic       PLAY_STOP,
  output logic [7:0] KEY_OUT,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NOTE = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [7:0]  c_silence   = 8'h30;
  localparam logic [23:0] c_note_last = 24'(NOTE_TICKS - 1);
  localparam logic [23:0] c_gap_last  = (GAP_TICKS > 0) ? 24'(GAP_TICKS - 1) : 24'd0;
  localparam logic        c_has_gap   = (GAP_TICKS > 0);
  localparam logic [3:0]  c_last_idx  = 4'(SONG_LEN - 1);

  state_t      r_state;
  logic [3:0]  r_idx;
  logic [23:0] r_cnt;
  logic [7:0]  r_key;
  logic        r_busy;
  logic        r_done;

  logic [7:0]  w_rom [0:15];
  logic        w_digit;
  logic        w_note_end;
  logic        w_gap_end;
  logic        w_last;
  logic [3:0]  w_idx_next;

  // Full 16-entry table keeps any 4-bit index in range; only SONG_LEN entries are played.
  for (genvar gi = 0; gi < 16; gi++) begin : g_rom
    assign w_rom[gi] = 8'h31 + 8'(gi % 9);
  end

  assign w_digit    = UART_VALID && (UART_DATA >= 8'h30) && (UART_DATA <= 8'h39);
  assign w_note_end = (r_cnt == c_note_last);
  assign w_gap_end  = (r_cnt == c_gap_last);
  assign w_last     = (r_idx == c_last_idx);
  assign w_idx_next = r_idx + 4'd1;

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_idx   <= 4'd0;
      r_cnt   <= 24'd0;
      r_key   <= c_silence;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A start strobe always consumes the cycle, even when a stop cancels it.
          if (PLAY_START) begin
            if (!PLAY_STOP) begin
              r_state <= ST_NOTE;
              r_idx   <= 4'd0;
              r_cnt   <= 24'd0;
              r_key   <= w_rom[0];
              r_busy  <= 1'b1;
            end
          end else if (w_digit) begin
            r_key <= UART_DATA;
          end
        end

        ST_NOTE, ST_GAP: begin
          if (PLAY_STOP) begin
            r_state <= ST_IDLE;
            r_idx   <= 4'd0;
            r_cnt   <= 24'd0;
            r_key   <= c_silence;
            r_busy  <= 1'b0;
          end
`ifdef UART_PREEMPT_EN
          else if (w_digit) begin
            r_state <= ST_IDLE;
            r_idx   <= 4'd0;
            r_cnt   <= 24'd0;
            r_key   <= UART_DATA;
            r_busy  <= 1'b0;
          end
`endif
          else if ((r_state == ST_NOTE) && !w_note_end) begin
            r_cnt <= r_cnt + 24'd1;
          end else if ((r_state == ST_NOTE) && c_has_gap) begin
            r_state <= ST_GAP;
            r_cnt   <= 24'd0;
            r_key   <= c_silence;
          end else if ((r_state == ST_GAP) && !w_gap_end) begin
            r_cnt <= r_cnt + 24'd1;
          end else if (!w_last) begin
            r_state <= ST_NOTE;
            r_idx   <= w_idx_next;
            r_cnt   <= 24'd0;
            r_key   <= w_rom[w_idx_next];
          end else begin
            r_state <= ST_IDLE;
            r_idx   <= 4'd0;
            r_cnt   <= 24'd0;
            r_key   <= c_silence;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_idx   <= 4'd0;
          r_cnt   <= 24'd0;
          r_key   <= c_silence;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign KEY_OUT = r_key;
  assign BUSY    = r_busy;
  assign DONE    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_beep_melody_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_beep_melody_ctrl: two instances (with and without gap) against a         |
// | timeline model of the song. Revision: 1.0                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_beep_melody_ctrl;

  localparam int NT = 4;
  localparam int GT = 2;
  localparam int SL = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] uart_data;
  logic       uart_valid;
  logic       play_start;
  logic       play_stop;
  logic [7:0] key_a, key_b;
  logic       busy_a, busy_b, done_a, done_b;

  int n_total = 0;
  int n_bad   = 0;

  int         gap_of [2] = '{GT, 0};
  bit         m_play [2];
  int         m_e    [2];
  logic [7:0] m_key  [2];
  bit         m_done [2];

  always #5 clk = ~clk;

  beep_melody_ctrl #(.NOTE_TICKS(NT), .GAP_TICKS(GT), .SONG_LEN(SL)) dut_a (
    .CLK_50M(clk), .RST_N(rst_n), .UART_DATA(uart_data), .UART_VALID(uart_valid),
    .PLAY_START(play_start), .PLAY_STOP(play_stop),
    .KEY_OUT(key_a), .BUSY(busy_a), .DONE(done_a)
  );

  beep_melody_ctrl #(.NOTE_TICKS(NT), .GAP_TICKS(0), .SONG_LEN(SL)) dut_b (
    .CLK_50M(clk), .RST_N(rst_n), .UART_DATA(uart_data), .UART_VALID(uart_valid),
    .PLAY_START(play_start), .PLAY_STOP(play_stop),
    .KEY_OUT(key_b), .BUSY(busy_b), .DONE(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_play[k] = 1'b0;
      m_e[k]    = 0;
      m_key[k]  = 8'h30;
      m_done[k] = 1'b0;
    end
  endtask

  // Expected key derived from elapsed cycles since the first NOTE cycle.
  function automatic logic [7:0] exp_key(input int k);
    int period, note, phase;
    if (!m_play[k]) return m_key[k];
    period = NT + gap_of[k];
    note   = m_e[k] / period;
    phase  = m_e[k] % period;
    return (phase < NT) ? (8'h31 + 8'(note % 9)) : 8'h30;
  endfunction

  task automatic model_step(input int k);
    bit digit;
    digit = uart_valid && (uart_data >= 8'h30) && (uart_data <= 8'h39);
    m_done[k] = 1'b0;
    if (m_play[k]) begin
      if (play_stop) begin
        m_play[k] = 1'b0;
        m_key[k]  = 8'h30;
      end
`ifdef UART_PREEMPT_EN
      else if (digit) begin
        m_play[k] = 1'b0;
        m_key[k]  = uart_data;
      end
`endif
      else begin
        m_e[k]++;
        if (m_e[k] == SL * (NT + gap_of[k])) begin
          m_play[k] = 1'b0;
          m_key[k]  = 8'h30;
          m_done[k] = 1'b1;
        end
      end
    end else if (play_start) begin
      if (!play_stop) begin
        m_play[k] = 1'b1;
        m_e[k]    = 0;
      end
    end else if (digit) begin
      m_key[k] = uart_data;
    end
  endtask

  task automatic check_all(input string tag);
    chk($sformatf("%s key_a", tag), 32'(key_a), 32'(exp_key(0)));
    chk($sformatf("%s busy_a", tag), 32'(busy_a), 32'(m_play[0]));
    chk($sformatf("%s done_a", tag), 32'(done_a), 32'(m_done[0]));
    chk($sformatf("%s key_b", tag), 32'(key_b), 32'(exp_key(1)));
    chk($sformatf("%s busy_b", tag), 32'(busy_b), 32'(m_play[1]));
    chk($sformatf("%s done_b", tag), 32'(done_b), 32'(m_done[1]));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
    #1;
    check_all(tag);
  endtask

  task automatic step(input string tag, input logic s, input logic p,
                      input logic v, input logic [7:0] d);
    play_start = s;
    play_stop  = p;
    uart_valid = v;
    uart_data  = d;
    tick(tag);
    play_start = 1'b0;
    play_stop  = 1'b0;
    uart_valid = 1'b0;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    rst_n      = 1'b0;
    uart_data  = 8'h00;
    uart_valid = 1'b0;
    play_start = 1'b0;
    play_stop  = 1'b0;
    model_reset();
    idle("reset", 2);
    #2 rst_n = 1'b1;
    idle("post_reset", 2);

    step("uart35", 1'b0, 1'b0, 1'b1, 8'h35);
    step("uart41", 1'b0, 1'b0, 1'b1, 8'h41);
    idle("hold35", 2);

    step("play", 1'b1, 1'b0, 1'b0, 8'h00);
    idle("song", 22);

    step("play_stop", 1'b1, 1'b0, 1'b0, 8'h00);
    idle("note1", 1);
    step("stop", 1'b0, 1'b1, 1'b0, 8'h00);
    idle("after_stop", 4);
    step("start_stop", 1'b1, 1'b1, 1'b0, 8'h00);
    idle("no_play", 4);

    step("play_rst", 1'b1, 1'b0, 1'b0, 8'h00);
    idle("to_gap", 4);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    idle("in_rst", 2);
    #2 rst_n = 1'b1;
    idle("after_rst", 22);

    step("play_uart", 1'b1, 1'b0, 1'b0, 8'h00);
    idle("note0", 1);
    step("uart37", 1'b0, 1'b0, 1'b1, 8'h37);
    idle("after37", 22);

    for (int i = 0; i < 2500; i++) begin
      logic s, p, v;
      logic [7:0] d;
      s = ($urandom_range(0, 7) == 0);
      p = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 5) == 0);
      d = ($urandom_range(0, 1) == 0) ? 8'(8'h30 + $urandom_range(0, 9))
                                      : 8'($urandom_range(0, 255));
      step("rand", s, p, v, d);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
